// File: rtl/bit_serial_alu.sv
// bit_serial_alu: LSB-first bit-serial add/subtract engine.
// One full-adder slice plus a carry flop iterates over WIDTH cycles.
// The registered sum, cout and signed ovf change only when an operation
// completes. done is a one-cycle pulse that marks each completion.
module bit_serial_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sh_reg,  a_sh_next;
    logic [WIDTH-1:0] b_sh_reg,  b_sh_next;
    // Holds the WIDTH-1 result bits produced so far. The final bit is
    // merged in directly at completion, so a full WIDTH-bit register is not needed.
    logic [WIDTH-2:0] res_sh_reg, res_sh_next;
    logic             carry_reg, carry_next;
    logic [CW-1:0]    cnt_reg,   cnt_next;
    logic [WIDTH-1:0] sum_reg,   sum_next;
    logic             cout_reg,  cout_next;
    logic             ovf_reg,   ovf_next;
    logic             done_reg,  done_next;

    logic [WIDTH-1:0] b_load;
    logic             slice_s;
    logic             slice_c;
    logic [WIDTH-1:0] res_shift;
    logic             last_bit;

    // Conditional inversion of operand B. Subtraction is a + ~b + 1, and
    // the +1 comes from the carry being preloaded with sub.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_b_inv
            assign b_load[gi] = b[gi] ^ sub;
        end
    endgenerate

    // One full-adder slice working on the current LSBs.
    assign slice_s   = a_sh_reg[0] ^ b_sh_reg[0] ^ carry_reg;
    assign slice_c   = (a_sh_reg[0] & b_sh_reg[0]) |
                       (a_sh_reg[0] & carry_reg)   |
                       (b_sh_reg[0] & carry_reg);
    assign res_shift = {slice_s, res_sh_reg};
    assign last_bit  = (cnt_reg == CW'(WIDTH - 1));

    assign busy = (state_reg == RUN);
    assign done = done_reg;
    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;

    // State and datapath registers; reset clears everything and aborts an operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            res_sh_reg <= '0;
            carry_reg  <= 1'b0;
            cnt_reg    <= '0;
            sum_reg    <= '0;
            cout_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            a_sh_reg   <= a_sh_next;
            b_sh_reg   <= b_sh_next;
            res_sh_reg <= res_sh_next;
            carry_reg  <= carry_next;
            cnt_reg    <= cnt_next;
            sum_reg    <= sum_next;
            cout_reg   <= cout_next;
            ovf_reg    <= ovf_next;
            done_reg   <= done_next;
        end
    end

    // Next-state logic: accept in IDLE, iterate one bit per enabled cycle in RUN.
    always_comb begin
        state_next  = state_reg;
        a_sh_next   = a_sh_reg;
        b_sh_next   = b_sh_reg;
        res_sh_next = res_sh_reg;
        carry_next  = carry_reg;
        cnt_next    = cnt_reg;
        sum_next    = sum_reg;
        cout_next   = cout_reg;
        ovf_next    = ovf_reg;
        done_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (ena && start) begin
                    a_sh_next  = a;
                    b_sh_next  = b_load;
                    carry_next = sub;
                    cnt_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (ena) begin
                    a_sh_next   = {1'b0, a_sh_reg[WIDTH-1:1]};
                    b_sh_next   = {1'b0, b_sh_reg[WIDTH-1:1]};
                    res_sh_next = res_shift[WIDTH-1:1];
                    carry_next  = slice_c;
                    cnt_next    = cnt_reg + CW'(1);
                    if (last_bit) begin
                        // carry_reg is the carry into the MSB slice at this point.
                        sum_next   = res_shift;
                        cout_next  = slice_c;
                        ovf_next   = carry_reg ^ slice_c;
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bit_serial_alu.sv
// tb_bit_serial_alu: directed tests of the bit-serial add/subtract engine.
// Expected values are hand-computed constants.
module tb_bit_serial_alu;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       start;
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;

    int total = 0;
    int bad   = 0;

    bit_serial_alu #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present an operation on a negedge; it is accepted on the next posedge.
    task automatic launch(input logic [7:0] av, input logic [7:0] bv, input logic sv);
        @(negedge clk);
        a = av; b = bv; sub = sv; start = 1'b1; ena = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Sample over a window of negedges. Index 0 is the first negedge after the accept edge.
    task automatic observe(input int window, output int first_done, output int busy_cycles,
                           output int done_cycles, output logic [7:0] mid_sum);
        first_done = -1; busy_cycles = 0; done_cycles = 0; mid_sum = 8'h00;
        for (int j = 0; j < window; j++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (done) begin
                done_cycles++;
                if (first_done < 0) first_done = j;
            end
            if (j == 4) mid_sum = sum;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; start = 1'b1;
        sub = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (sum !== 8'h00) begin bad++; $display("FAIL reset_sum: got %h want 00", sum); end
        total++; if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout: got %b want 0", cout); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL release_busy: got %b want 0", busy); end
        $display("reset: busy=%b done=%b sum=%h cout=%b ovf=%b", busy, done, sum, cout, ovf);
    endtask

    task automatic test_add_basic();
        int fd, bc, dc;
        logic [7:0] mid;
        launch(8'h5A, 8'h3C, 1'b0);
        observe(12, fd, bc, dc, mid);
        $display("add 5a+3c -> sum=%h cout=%b ovf=%b lat=%0d busy=%0d", sum, cout, ovf, fd, bc);
        total++; if (mid !== 8'h00) begin bad++; $display("FAIL add_mid_sum: got %h want 00", mid); end
        total++; if (fd !== 8) begin bad++; $display("FAIL add_latency: got %0d want 8", fd); end
        total++; if (bc !== 8) begin bad++; $display("FAIL add_busy_cycles: got %0d want 8", bc); end
        total++; if (dc !== 1) begin bad++; $display("FAIL add_done_pulses: got %0d want 1", dc); end
        total++; if (sum !== 8'h96) begin bad++; $display("FAIL add_sum: got %h want 96", sum); end
        total++; if (cout !== 1'b0) begin bad++; $display("FAIL add_cout: got %b want 0", cout); end
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL add_ovf: got %b want 1", ovf); end
    endtask

    task automatic test_back_to_back();
        int fd, bc, dc;
        logic [7:0] mid;
        launch(8'hFF, 8'h01, 1'b0);
        fd = -1;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (done) begin
                fd = j;
                break;
            end
        end
        $display("add ff+01 -> sum=%h cout=%b ovf=%b lat=%0d", sum, cout, ovf, fd);
        total++; if (fd !== 8) begin bad++; $display("FAIL wrap_latency: got %0d want 8", fd); end
        total++; if (sum !== 8'h00) begin bad++; $display("FAIL wrap_sum: got %h want 00", sum); end
        total++; if (cout !== 1'b1) begin bad++; $display("FAIL wrap_cout: got %b want 1", cout); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL wrap_ovf: got %b want 0", ovf); end
        // Start is raised in the cycle done is high.
        a = 8'h7F; b = 8'h01; sub = 1'b0; start = 1'b1; ena = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        observe(12, fd, bc, dc, mid);
        $display("add 7f+01 (b2b) -> sum=%h cout=%b ovf=%b lat=%0d", sum, cout, ovf, fd);
        total++; if (mid !== 8'h00) begin bad++; $display("FAIL b2b_held_sum: got %h want 00", mid); end
        total++; if (fd !== 8) begin bad++; $display("FAIL b2b_latency: got %0d want 8", fd); end
        total++; if (dc !== 1) begin bad++; $display("FAIL b2b_done_pulses: got %0d want 1", dc); end
        total++; if (sum !== 8'h80) begin bad++; $display("FAIL b2b_sum: got %h want 80", sum); end
        total++; if (cout !== 1'b0) begin bad++; $display("FAIL b2b_cout: got %b want 0", cout); end
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL b2b_ovf: got %b want 1", ovf); end
    endtask

    task automatic test_sub();
        int fd, bc, dc;
        logic [7:0] mid;
        launch(8'h10, 8'h20, 1'b1);
        observe(12, fd, bc, dc, mid);
        $display("sub 10-20 -> sum=%h cout=%b ovf=%b lat=%0d", sum, cout, ovf, fd);
        total++; if (fd !== 8) begin bad++; $display("FAIL sub1_latency: got %0d want 8", fd); end
        total++; if (sum !== 8'hF0) begin bad++; $display("FAIL sub1_sum: got %h want f0", sum); end
        total++; if (cout !== 1'b0) begin bad++; $display("FAIL sub1_cout: got %b want 0", cout); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL sub1_ovf: got %b want 0", ovf); end
        launch(8'h80, 8'h01, 1'b1);
        observe(12, fd, bc, dc, mid);
        $display("sub 80-01 -> sum=%h cout=%b ovf=%b lat=%0d", sum, cout, ovf, fd);
        total++; if (sum !== 8'h7F) begin bad++; $display("FAIL sub2_sum: got %h want 7f", sum); end
        total++; if (cout !== 1'b1) begin bad++; $display("FAIL sub2_cout: got %b want 1", cout); end
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL sub2_ovf: got %b want 1", ovf); end
    endtask

    task automatic test_stall();
        int fd, bc, dc;
        launch(8'h12, 8'h34, 1'b0);
        fd = -1; bc = 0; dc = 0;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            if (busy) bc++;
            if (done) begin
                dc++;
                if (fd < 0) fd = j;
            end
            // Three stalled edges, then a start pulse while busy.
            ena = !(j >= 2 && j < 5);
            start = (j == 6);
            if (j == 6) begin
                a = 8'hFF; b = 8'hFF;
            end
        end
        ena = 1'b1; start = 1'b0;
        $display("add 12+34 stalled -> sum=%h cout=%b ovf=%b lat=%0d busy=%0d dones=%0d",
                 sum, cout, ovf, fd, bc, dc);
        total++; if (fd !== 11) begin bad++; $display("FAIL stall_latency: got %0d want 11", fd); end
        total++; if (bc !== 11) begin bad++; $display("FAIL stall_busy_cycles: got %0d want 11", bc); end
        total++; if (dc !== 1) begin bad++; $display("FAIL stall_done_pulses: got %0d want 1", dc); end
        total++; if (sum !== 8'h46) begin bad++; $display("FAIL stall_sum: got %h want 46", sum); end
        total++; if (cout !== 1'b0) begin bad++; $display("FAIL stall_cout: got %b want 0", cout); end
    endtask

    task automatic test_reset_abort();
        int fd, bc, dc;
        logic [7:0] mid;
        launch(8'hAA, 8'h55, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        total++; if (sum !== 8'h00) begin bad++; $display("FAIL abort_sum: got %h want 00", sum); end
        @(negedge clk);
        rst_n = 1'b1;
        dc = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (done) dc++;
        end
        $display("abort aa+55 -> sum=%h dones=%0d", sum, dc);
        total++; if (dc !== 0) begin bad++; $display("FAIL abort_done_pulses: got %0d want 0", dc); end
        total++; if (sum !== 8'h00) begin bad++; $display("FAIL abort_sum_after: got %h want 00", sum); end
        launch(8'h01, 8'h02, 1'b0);
        observe(12, fd, bc, dc, mid);
        $display("add 01+02 -> sum=%h cout=%b ovf=%b lat=%0d", sum, cout, ovf, fd);
        total++; if (mid !== 8'h00) begin bad++; $display("FAIL post_mid_sum: got %h want 00", mid); end
        total++; if (fd !== 8) begin bad++; $display("FAIL post_latency: got %0d want 8", fd); end
        total++; if (dc !== 1) begin bad++; $display("FAIL post_done_pulses: got %0d want 1", dc); end
        total++; if (sum !== 8'h03) begin bad++; $display("FAIL post_sum: got %h want 03", sum); end
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b0; start = 1'b0; sub = 1'b0; a = 8'h00; b = 8'h00;
        test_reset();
        test_add_basic();
        test_back_to_back();
        test_sub();
        test_stall();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bit_serial_alu.md
Name: bit_serial_alu

Overview:
- LSB-first bit-serial add/subtract engine, built as the sequential successor to the combinational half-adder slice (sum = a^b, carry = a&b).
- Takes two parallel WIDTH-bit operands and iterates one full-adder slice plus a carry flop over WIDTH cycles.
- Presents a registered sum, carry-out and signed-overflow result with a one-cycle done pulse.
- Intended to sit behind the chip-level pin wrapper: operands come from the dedicated inputs, results go to the outputs.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- ena  input  1  advance enable; 0 stalls acceptance and iteration.
- start  input  1  request a new operation; sampled only in IDLE with ena=1.
- sub  input  1  0 = a+b, 1 = a-b; latched with start.
- a  input  WIDTH  operand A; latched with start.
- b  input  WIDTH  operand B; latched with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when a result is written.
- sum  output  WIDTH  registered result; holds until the next completion.
- cout  output  1  final carry; in sub mode, 1 = no borrow (a >= b unsigned).
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - busy, done, sum, cout, ovf, internal carry, bit counter and shift registers all clear to 0.
  - Release is synchronous to the next clk edge.
- States: IDLE, RUN. done is a registered pulse, not a state.
- IDLE:
  - On an edge with start=1 and ena=1:
    - Load shift register A with a.
    - Load shift register B with b, or with ~b when sub=1.
    - Set carry to sub and counter to 0.
    - Go to RUN. busy goes high after this edge.
  - start with ena=0 is ignored.
- RUN, on each edge with ena=1:
  - s = A[0]^B[0]^c.
  - c_next = majority(A[0], B[0], c).
  - Shift s into the MSB of the result shift register; shift A and B right by one; counter increments.
  - Record the carry entering the MSB slice, i.e. c on the edge where counter == WIDTH-1.
- Completion, on the edge where counter == WIDTH-1 is processed:
  - sum takes the completed result register.
  - cout takes c_next.
  - ovf takes (recorded MSB carry-in XOR c_next).
  - done goes high for exactly one cycle.
  - busy goes low and state returns to IDLE.
- Latency: start accepted at edge k with no stalls gives done high in the cycle after edge k+WIDTH. busy is high for exactly WIDTH cycles.
- ena=0 in RUN: all state, counter, carry and shift registers hold. Each stalled cycle adds one cycle of latency. done is never held longer than one cycle.
- start while busy=1 is ignored. It is not queued.
- start present on the cycle done is high is accepted, because the state is already IDLE (back-to-back operation).
- sum, cout and ovf change only at completion. They are never visible mid-operation.
- Reset asserted mid-operation aborts immediately to the reset values. No done pulse is issued.
- Arithmetic is modulo 2^WIDTH. Subtraction is two's complement (a + ~b + 1).

Test Plan:
1. Assert rst_n=0 with start=1 and random operands -> busy=0, done=0, sum=0, cout=0, ovf=0; no activity until release.
2. WIDTH=8, add 0x5A+0x3C, ena=1 -> sum=0x96, cout=0, ovf=1; done high exactly in the cycle after start edge+8; busy high 8 cycles.
3. Add 0xFF+0x01 -> sum=0x00, cout=1, ovf=0. Then back-to-back start on the done cycle with 0x7F+0x01 -> sum=0x80, cout=0, ovf=1, done 8 cycles later.
4. Sub 0x10-0x20 -> sum=0xF0, cout=0, ovf=0. Sub 0x80-0x01 -> sum=0x7F, cout=1, ovf=1.
5. Start 0x12+0x34, drop ena for 3 cycles mid-run, and pulse start while busy -> sum=0x46; done delayed by exactly 3 cycles; the second start is ignored (only one done pulse).
6. Start 0xAA+0x55, assert rst_n low after 4 RUN cycles, release, then start 0x01+0x02 -> no done for the aborted op; sum stays 0 until the new result 0x03 with one done pulse.
